// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data_mem arbiter: FSM encoding, port ids and
// the alignment helper used on the request path.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic       PORT_LSU   = 1'b0;
    localparam logic       PORT_DBG   = 1'b1;
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    function automatic logic is_misaligned(input logic [2:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer port wins when it requests,
// otherwise the other port; the pointer is reloaded on advance.
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr_reg
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg <= PORT_LSU;
        end else if (advance) begin
            ptr_reg <= ptr;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req[ptr_reg]) begin
            gnt[ptr_reg] = 1'b1;
        end else if (req[~ptr_reg]) begin
            gnt[~ptr_reg] = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data_mem between the load/store unit (port 0) and
// the debug loader (port 1), one access in flight, round-robin grant.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MEM_RD_LAT  = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_read_data
);

    arb_state_t state_reg, state_next;

    logic              we_reg;
    logic              port_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [DATA_W-1:0] write_data_reg;

    logic [1:0]        valid_vec;
    logic [1:0]        gnt;
    logic [1:0]        ready_vec;
    logic [1:0]        rsp_vec;
    logic              ptr_reg;
    logic              handshake;
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_misaligned;
    logic              capture;
    logic [DATA_W-1:0] rsp_data [2];
    logic              rsp_err  [2];

    assign valid_vec = {req1_valid, req0_valid};

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (valid_vec),
        .ptr     (~port_reg),
        .advance (state_reg == DONE),
        .gnt     (gnt),
        .ptr_reg (ptr_reg)
    );

    // Ready is held low while reset is asserted so nothing can be accepted
    // in the same cycle the block is being cleared.
    assign ready_vec  = (state_reg == IDLE && reset) ? gnt : 2'b00;
    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign handshake  = |ready_vec;

    assign sel_port       = gnt[1];
    assign sel_we         = sel_port ? req1_we    : req0_we;
    assign sel_addr       = sel_port ? req1_addr  : req0_addr;
    assign sel_wdata      = sel_port ? req1_wdata : req0_wdata;
    assign sel_misaligned = (ALIGN_CHECK != 0) && is_misaligned(sel_addr[2:0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    state_next = sel_misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_MemWrite = we_reg;
                mem_MemRead  = ~we_reg;
                if (we_reg || MEM_RD_LAT == 0) begin
                    capture    = ~we_reg;
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory-facing address/data registers only load for requests that
    // will actually strobe, so they stay put across error responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_reg         <= 1'b0;
            port_reg       <= PORT_LSU;
            err_reg        <= 1'b0;
            rdata_reg      <= '0;
            address_reg    <= '0;
            write_data_reg <= '0;
        end else if (handshake) begin
            we_reg    <= sel_we;
            port_reg  <= sel_port;
            err_reg   <= sel_misaligned;
            rdata_reg <= '0;
            if (!sel_misaligned) begin
                address_reg    <= sel_addr;
                write_data_reg <= sel_wdata;
            end
        end else if (capture) begin
            rdata_reg <= mem_read_data;
        end
    end

    assign mem_address    = address_reg;
    assign mem_write_data = write_data_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_vec[gi]  = (state_reg == DONE) && (port_reg == 1'(gi));
        assign rsp_data[gi] = rsp_vec[gi] ? rdata_reg : '0;
        assign rsp_err[gi]  = rsp_vec[gi] & err_reg;
    end

    assign rsp0_valid = rsp_vec[0];
    assign rsp0_rdata = rsp_data[0];
    assign rsp0_err   = rsp_err[0];
    assign rsp1_valid = rsp_vec[1];
    assign rsp1_rdata = rsp_data[1];
    assign rsp1_err   = rsp_err[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a registered-read memory build
// (MEM_RD_LAT=1) carries most steps, a combinational-read build checks latency 0.
module tb_data_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_err;
    logic req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_err;
    logic [AW-1:0] req0_addr, req1_addr, mem_address;
    logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic mem_MemRead, mem_MemWrite;

    logic b_req0_valid, b_req0_ready, b_req0_we, b_rsp0_valid, b_rsp0_err;
    logic b_req1_valid, b_req1_ready, b_req1_we, b_rsp1_valid, b_rsp1_err;
    logic [AW-1:0] b_req0_addr, b_req1_addr, b_mem_address;
    logic [DW-1:0] b_req0_wdata, b_req1_wdata, b_rsp0_rdata, b_rsp1_rdata;
    logic [DW-1:0] b_mem_write_data, b_mem_read_data;
    logic b_mem_MemRead, b_mem_MemWrite;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(1), .ALIGN_CHECK(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_read_data(mem_read_data)
    );

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(0), .ALIGN_CHECK(1)) dut_lat0 (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(b_req0_we),
        .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata), .rsp0_err(b_rsp0_err),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_we(b_req1_we),
        .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata), .rsp1_err(b_rsp1_err),
        .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
        .mem_MemRead(b_mem_MemRead), .mem_MemWrite(b_mem_MemWrite),
        .mem_read_data(b_mem_read_data)
    );

    // Memory models: registered read for the main build, combinational for the other.
    logic [DW-1:0] mem   [0:511];
    logic [DW-1:0] mem_b [0:511];
    logic [DW-1:0] rd_q = '0;

    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_address[11:3]] <= mem_write_data;
        if (mem_MemRead)  rd_q <= mem[mem_address[11:3]];
        if (b_mem_MemWrite) mem_b[b_mem_address[11:3]] <= b_mem_write_data;
    end
    assign mem_read_data   = rd_q;
    assign b_mem_read_data = mem_b[b_mem_address[11:3]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Event log gathered on the falling edge.
    int            grant_q    [$];
    int            rsp_port_q [$];
    logic [DW-1:0] rsp_data_q [$];
    logic          rsp_err_q  [$];
    int hs0_cnt = 0, hs1_cnt = 0, rsp_cnt = 0, strobe_cnt = 0;
    int hs_cyc = 0, rsp_cyc = 0, wr_cyc = 0;

    always @(negedge clk) begin
        chk("rw_exclusive", 64'(mem_MemRead & mem_MemWrite), 64'd0);
        chk("one_ready", 64'(req0_ready & req1_ready), 64'd0);
        chk("one_rsp", 64'(rsp0_valid & rsp1_valid), 64'd0);
        if (!rsp0_valid) chk("rsp0_quiet", rsp0_rdata | 64'(rsp0_err), 64'd0);
        if (!rsp1_valid) chk("rsp1_quiet", rsp1_rdata | 64'(rsp1_err), 64'd0);
        if (reset) begin
            if (req0_valid && req0_ready) begin grant_q.push_back(0); hs0_cnt++; hs_cyc = cyc; end
            if (req1_valid && req1_ready) begin grant_q.push_back(1); hs1_cnt++; hs_cyc = cyc; end
            if (mem_MemWrite) begin strobe_cnt++; wr_cyc = cyc; end
            if (mem_MemRead)  strobe_cnt++;
            if (rsp0_valid) begin
                rsp_port_q.push_back(0); rsp_data_q.push_back(rsp0_rdata);
                rsp_err_q.push_back(rsp0_err); rsp_cnt++; rsp_cyc = cyc;
            end
            if (rsp1_valid) begin
                rsp_port_q.push_back(1); rsp_data_q.push_back(rsp1_rdata);
                rsp_err_q.push_back(rsp1_err); rsp_cnt++; rsp_cyc = cyc;
            end
        end
    end

    task automatic clear_log();
        grant_q.delete(); rsp_port_q.delete(); rsp_data_q.delete(); rsp_err_q.delete();
    endtask

    // Each port issues n identical requests back-to-back; returns when all responses are logged.
    task automatic run_ports(input int n0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input int n1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int h0 = hs0_cnt;
        int h1 = hs1_cnt;
        int r  = rsp_cnt;
        logic done = 1'b0;
        req0_we = we0; req0_addr = a0; req0_wdata = d0; req0_valid = (n0 > 0);
        req1_we = we1; req1_addr = a1; req1_wdata = d1; req1_valid = (n1 > 0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            req0_valid = (hs0_cnt - h0) < n0;
            req1_valid = (hs1_cnt - h1) < n1;
            if ((rsp_cnt - r) == n0 + n1 && !req0_valid && !req1_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("run_complete", 64'(done), 64'd1);
    endtask

    task automatic expect_rsp(input string tag, input int port, input logic [DW-1:0] data, input logic err);
        int p;
        logic [DW-1:0] d;
        logic e;
        if (rsp_port_q.size() == 0) begin
            chk({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            p = rsp_port_q.pop_front();
            d = rsp_data_q.pop_front();
            e = rsp_err_q.pop_front();
            $display("txn %s: port=%0d rdata=%h err=%0d", tag, p, d, e);
            chk({tag, "_port"}, 64'(p), 64'(port));
            chk({tag, "_rdata"}, d, data);
            chk({tag, "_err"}, 64'(e), 64'(err));
        end
    endtask

    initial begin
        int n, s, lat, hs;
        logic found;
        logic [DW-1:0] got;

        reset = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        b_req0_valid = 1'b0; b_req0_we = 1'b0; b_req0_addr = '0; b_req0_wdata = '0;
        b_req1_valid = 1'b0; b_req1_we = 1'b0; b_req1_addr = '0; b_req1_wdata = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i]   = 64'h5A5A5A5A00000000 | 64'(i);
            mem_b[i] = 64'h5A5A5A5A00000000 | 64'(i);
        end
        mem_b[9'h020] = 64'h1122334455667788;

        // Reset state, with both requesters pushing.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_rsp_err", 64'({rsp0_err, rsp1_err}), 64'd0);
        chk("rst_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
        chk("rst_mem_address", mem_address, 64'd0);
        chk("rst_mem_write_data", mem_write_data, 64'd0);
        chk("rst_rsp_rdata", rsp0_rdata | rsp1_rdata, 64'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b1;

        // Simultaneous writes right after reset: port 0 first.
        clear_log();
        run_ports(1, 1'b1, 64'h200, 64'hDEADBEEFCAFEBABE, 1, 1'b1, 64'h208, 64'hFFFFFFFFFFFFFFFF);
        chk("both_wr_grants", 64'(grant_q.size()), 64'd2);
        if (grant_q.size() == 2) begin
            chk("both_wr_first", 64'(grant_q[0]), 64'd0);
            chk("both_wr_second", 64'(grant_q[1]), 64'd1);
        end
        expect_rsp("both_wr_p0", 0, 64'd0, 1'b0);
        expect_rsp("both_wr_p1", 1, 64'd0, 1'b0);

        // Port 0 write then read of 0x100 with latency checks.
        clear_log();
        run_ports(1, 1'b1, 64'h100, 64'h1122334455667788, 0, 1'b0, 64'h0, 64'h0);
        chk("wr_strobe_lat", 64'(wr_cyc - hs_cyc), 64'd1);
        chk("wr_rsp_lat", 64'(rsp_cyc - hs_cyc), 64'd2);
        expect_rsp("wr100", 0, 64'd0, 1'b0);
        clear_log();
        run_ports(1, 1'b0, 64'h100, 64'h0, 0, 1'b0, 64'h0, 64'h0);
        chk("rd_rsp_lat", 64'(rsp_cyc - hs_cyc), 64'd3);
        expect_rsp("rd100", 0, 64'h1122334455667788, 1'b0);

        // Readback of the simultaneous writes.
        clear_log();
        run_ports(1, 1'b0, 64'h200, 64'h0, 0, 1'b0, 64'h0, 64'h0);
        expect_rsp("rd200", 0, 64'hDEADBEEFCAFEBABE, 1'b0);
        clear_log();
        run_ports(0, 1'b0, 64'h0, 64'h0, 1, 1'b0, 64'h208, 64'h0);
        expect_rsp("rd208", 1, 64'hFFFFFFFFFFFFFFFF, 1'b0);

        // Four back-to-back reads per port: grants alternate.
        clear_log();
        run_ports(4, 1'b0, 64'h200, 64'h0, 4, 1'b0, 64'h208, 64'h0);
        chk("rr_grant_count", 64'(grant_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_q.size()) chk($sformatf("rr_grant%0d", i), 64'(grant_q[i]), 64'(i % 2));
        end
        for (int i = 0; i < 8; i++) begin
            expect_rsp($sformatf("rr_rsp%0d", i), i % 2,
                       (i % 2 == 0) ? 64'hDEADBEEFCAFEBABE : 64'hFFFFFFFFFFFFFFFF, 1'b0);
        end

        // Misaligned port 1 read: immediate error, no strobe.
        clear_log();
        s = strobe_cnt;
        run_ports(0, 1'b0, 64'h0, 64'h0, 1, 1'b0, 64'h301, 64'h0);
        chk("mis_rsp_lat", 64'(rsp_cyc - hs_cyc), 64'd1);
        chk("mis_no_strobe", 64'(strobe_cnt - s), 64'd0);
        expect_rsp("mis301", 1, 64'd0, 1'b1);
        clear_log();
        run_ports(0, 1'b0, 64'h0, 64'h0, 1, 1'b0, 64'h300, 64'h0);
        expect_rsp("rd300", 1, 64'h5A5A5A5A00000060, 1'b0);

        // Move the pointer to port 1, then reset during a port 0 read in WAIT.
        clear_log();
        run_ports(1, 1'b0, 64'h100, 64'h0, 0, 1'b0, 64'h0, 64'h0);
        expect_rsp("rd100_again", 0, 64'h1122334455667788, 1'b0);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 64'h100;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req0_ready) begin found = 1'b1; break; end
        end
        chk("abort_handshake", 64'(found), 64'd1);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        n = rsp_cnt;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("abort_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
        chk("abort_rsp0", 64'(rsp0_valid), 64'd0);
        repeat (3) @(posedge clk); #1;
        chk("abort_no_rsp", 64'(rsp_cnt - n), 64'd0);
        clear_log();
        run_ports(1, 1'b0, 64'h100, 64'h0, 1, 1'b1, 64'h400, 64'h0);
        if (grant_q.size() > 0) chk("abort_ptr_port0", 64'(grant_q[0]), 64'd0);
        else chk("abort_grant_seen", 64'd0, 64'd1);
        expect_rsp("post_rd100", 0, 64'h1122334455667788, 1'b0);
        expect_rsp("wr400", 1, 64'd0, 1'b0);
        clear_log();
        run_ports(0, 1'b0, 64'h0, 64'h0, 1, 1'b0, 64'h400, 64'h0);
        expect_rsp("rd400", 1, 64'd0, 1'b0);

        // Latency-0 build: read 0x100 responds two cycles after the handshake.
        @(posedge clk); #1;
        b_req0_valid = 1'b1; b_req0_we = 1'b0; b_req0_addr = 64'h100;
        found = 1'b0; hs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_req0_ready) begin found = 1'b1; hs = cyc; break; end
        end
        chk("lat0_handshake", 64'(found), 64'd1);
        @(posedge clk); #1; b_req0_valid = 1'b0;
        found = 1'b0; lat = 0; got = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_rsp0_valid) begin found = 1'b1; lat = cyc - hs; got = b_rsp0_rdata; break; end
        end
        $display("txn lat0_rd100: found=%0d lat=%0d rdata=%h", found, lat, got);
        chk("lat0_rsp_seen", 64'(found), 64'd1);
        chk("lat0_rsp_lat", 64'(lat), 64'd2);
        chk("lat0_rdata", got, 64'h1122334455667788);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
